// File: rtl/counter_mod_n.sv
// Parametrised modulo-N up/down counter with load, carry/borrow pulse and zero flag.
// Define COUNTER_MOD_N_SAT_EN to saturate at 0 / MOD-1 instead of wrapping.
module counter_mod_n #(
   parameter int     WIDTH = 4,
   parameter longint MOD   = 16,
   parameter longint STEP  = 1,
   parameter longint INIT  = 0
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             CE,
   input  logic             UP,
   input  logic             LD,
   input  logic [WIDTH-1:0] LD_VAL,
   output logic [WIDTH-1:0] O,
   output logic             COUT,
   output logic             ZERO
);

   // Compares run at WIDTH+1 bits so MOD = 2^WIDTH needs no special case.
   localparam logic [WIDTH:0]   MOD_E  = (WIDTH+1)'(MOD);
   localparam logic [WIDTH:0]   STEP_E = (WIDTH+1)'(STEP);
   localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);
   localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MOD - 1);
   localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

   logic [WIDTH-1:0] o_q, o_d;
   logic             cout_q, cout_d;

   // Returns {boundary_crossed, next_count} for an upward step.
   function automatic logic [WIDTH:0] step_up(input logic [WIDTH-1:0] cur);
      logic [WIDTH:0] s;
      s = {1'b0, cur} + STEP_E;
      if (s >= MOD_E) begin
`ifdef COUNTER_MOD_N_SAT_EN
         return {1'b1, MAX_V};
`else
         return {1'b1, WIDTH'(s - MOD_E)};
`endif
      end
      return {1'b0, s[WIDTH-1:0]};
   endfunction

   // Returns {boundary_crossed, next_count} for a downward step.
   function automatic logic [WIDTH:0] step_dn(input logic [WIDTH-1:0] cur);
      if ({1'b0, cur} < STEP_E) begin
`ifdef COUNTER_MOD_N_SAT_EN
         return {1'b1, {WIDTH{1'b0}}};
`else
         return {1'b1, WIDTH'({1'b0, cur} + MOD_E - STEP_E)};
`endif
      end
      return {1'b0, cur - STEP_V};
   endfunction

   function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
      if ({1'b0, v} >= MOD_E) return MAX_V;
      return v;
   endfunction

   always_comb begin
      o_d    = o_q;
      cout_d = 1'b0;
      if (LD) begin
         o_d = clamp_load(LD_VAL);
      end else if (CE) begin
         if (UP) {cout_d, o_d} = step_up(o_q);
         else    {cout_d, o_d} = step_dn(o_q);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         o_q    <= INIT_V;
         cout_q <= 1'b0;
      end else begin
         o_q    <= o_d;
         cout_q <= cout_d;
      end
   end

   assign O    = o_q;
   assign COUT = cout_q;
   assign ZERO = (o_q == '0);

endmodule
